// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, shadow-slot record, hazard match helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_pipe_pkg;

  // Width of register addresses held in the shadow slots (32 architectural regs).
  localparam int PIPE_AW = 5;

  // EXE operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register-file / ID/EXE operand
  localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in MEM

  // Destination/source info shadowed for one in-flight instruction.
  typedef struct packed {
    logic               valid;
    logic [PIPE_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic [PIPE_AW-1:0] rs1;
    logic [PIPE_AW-1:0] rs2;
  } slot_t;

  // A slot produces register r. x0 is hardwired zero and never creates a hazard.
  function automatic logic hz_match(input slot_t s, input logic [PIPE_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipe_shadow_slot.sv
// One pipeline shadow slot: captures slot_i when load_i is high, otherwise becomes a bubble.
// Latency: 1 cycle (registered). Backpressure: none, updates every cycle.
// Ports: clk, reset (sync, active-high), load_i (take slot_i), slot_i (next record), slot_o (held record).
module pipe_shadow_slot
  import riscv_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  slot_t slot_i,
  output slot_t slot_o
);

  slot_t slot_q;
  slot_t slot_d;

  // A bubble clears every field, not just valid, so stale rs/rd never leak anywhere.
  always_comb begin
    slot_d = '0;
    if (load_i) begin
      slot_d = slot_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: stalls, flushes, EXE forwarding selects, perf counters.
// Latency: control outputs are combinational from shadow slots and ID/EXE inputs; slots advance every cycle.
// Backpressure: stall_f/stall_d hold the front end on load-use (or any RAW when forwarding is off); branch flush wins.
// Ports: clk, reset; ID instruction fields (id_*); pcsrc_e; stall_f/stall_d/flush_d/flush_e; fwd_a_e/fwd_b_e; stall_cnt/flush_cnt.
module hazard_ctrl_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW     = PIPE_AW,  // must not exceed PIPE_AW
  parameter int FWD_EN     = 1,
  parameter int LOAD_STALL = 1,        // 1..3
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              pcsrc_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] BUB_INIT = 2'(LOAD_STALL - 1);

  slot_t              id_slot;
  slot_t              exe_slot;
  slot_t              mem_slot;
  slot_t              wb_slot;
  logic [PIPE_AW-1:0] rs1_w;
  logic [PIPE_AW-1:0] rs2_w;
  logic               exe_load;
  logic               load_use;
  logic               raw_stall;
  logic               bub_stall;
  logic               hz_stall;
  logic [1:0]         bub_q;
  logic [1:0]         bub_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_d;

  assign rs1_w = PIPE_AW'(id_rs1);
  assign rs2_w = PIPE_AW'(id_rs2);

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = 1'b1;
    id_slot.rd        = PIPE_AW'(id_rd);
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
    id_slot.rs1       = rs1_w;
    id_slot.rs2       = rs2_w;
  end

  // EXE takes the ID instruction unless it is being bubbled; MEM and WB simply follow.
  assign exe_load = id_valid & ~flush_e;

  pipe_shadow_slot u_exe_slot (
    .clk    (clk),
    .reset  (reset),
    .load_i (exe_load),
    .slot_i (id_slot),
    .slot_o (exe_slot)
  );

  pipe_shadow_slot u_mem_slot (
    .clk    (clk),
    .reset  (reset),
    .load_i (1'b1),
    .slot_i (exe_slot),
    .slot_o (mem_slot)
  );

  pipe_shadow_slot u_wb_slot (
    .clk    (clk),
    .reset  (reset),
    .load_i (1'b1),
    .slot_i (mem_slot),
    .slot_o (wb_slot)
  );

  // Hazard detection. All stall sources are gated by id_valid so an empty ID never stalls.
  always_comb begin
    load_use  = 1'b0;
    raw_stall = 1'b0;
    bub_stall = 1'b0;
    if (FWD_EN != 0) begin
      load_use  = id_valid && exe_slot.mem_read &&
                  (hz_match(exe_slot, rs1_w) || hz_match(exe_slot, rs2_w));
      // Extra bubbles beyond the first come from the countdown.
      bub_stall = id_valid && (bub_q != 2'd0);
    end else begin
      raw_stall = id_valid &&
                  (hz_match(exe_slot, rs1_w) || hz_match(exe_slot, rs2_w) ||
                   hz_match(mem_slot, rs1_w) || hz_match(mem_slot, rs2_w) ||
                   hz_match(wb_slot,  rs1_w) || hz_match(wb_slot,  rs2_w));
    end
    hz_stall = load_use | raw_stall | bub_stall;
  end

  // A taken branch squashes the ID instruction, so it overrides any stall.
  assign stall_f = hz_stall & ~pcsrc_e;
  assign stall_d = hz_stall & ~pcsrc_e;
  assign flush_d = pcsrc_e;
  assign flush_e = pcsrc_e | hz_stall;

  // Forwarding: the younger producer in MEM beats WB.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (FWD_EN != 0) begin
      if (hz_match(mem_slot, exe_slot.rs1))     fwd_a_e = FWD_MEM;
      else if (hz_match(wb_slot, exe_slot.rs1)) fwd_a_e = FWD_WB;
      if (hz_match(mem_slot, exe_slot.rs2))     fwd_b_e = FWD_MEM;
      else if (hz_match(wb_slot, exe_slot.rs2)) fwd_b_e = FWD_WB;
    end
  end

  // Bubble countdown and saturating performance counters.
  always_comb begin
    bub_d = bub_q;
    if (pcsrc_e) begin
      bub_d = 2'd0;
    end else if (load_use) begin
      bub_d = BUB_INIT;
    end else if (bub_q != 2'd0) begin
      bub_d = bub_q - 2'd1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (pcsrc_e && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bub_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Fields carried for uniformity of the slot record but not consumed downstream.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_slot.rs1, mem_slot.rs2, mem_slot.mem_read,
                              wb_slot.rs1, wb_slot.rs2, wb_slot.mem_read};

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, pcsrc_e;

  always #5 clk = ~clk;

  // Instance A: defaults (forwarding, LOAD_STALL=1)
  logic a_stall_f, a_stall_d, a_flush_d, a_flush_e;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  // Instance B: LOAD_STALL=2
  logic b_stall_f, b_stall_d, b_flush_d, b_flush_e;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [31:0] b_stall_cnt, b_flush_cnt;
  // Instance C: stall-only, 4-bit counters
  logic c_stall_f, c_stall_d, c_flush_d, c_flush_e;
  logic [1:0] c_fwd_a, c_fwd_b;
  logic [3:0] c_stall_cnt, c_flush_cnt;

  hazard_ctrl_unit u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .pcsrc_e(pcsrc_e),
    .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_d(a_flush_d), .flush_e(a_flush_e),
    .fwd_a_e(a_fwd_a), .fwd_b_e(a_fwd_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_ctrl_unit #(.LOAD_STALL(2)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .pcsrc_e(pcsrc_e),
    .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d), .flush_e(b_flush_e),
    .fwd_a_e(b_fwd_a), .fwd_b_e(b_fwd_b), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  hazard_ctrl_unit #(.FWD_EN(0), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .pcsrc_e(pcsrc_e),
    .stall_f(c_stall_f), .stall_d(c_stall_d), .flush_d(c_flush_d), .flush_e(c_flush_e),
    .fwd_a_e(c_fwd_a), .fwd_b_e(c_fwd_b), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

  logic [7:0] a_o, b_o, c_o;
  assign a_o = {a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_fwd_a, a_fwd_b};
  assign b_o = {b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_fwd_a, b_fwd_b};
  assign c_o = {c_stall_f, c_stall_d, c_flush_d, c_flush_e, c_fwd_a, c_fwd_b};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, pc;
    logic       st, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input int v, input int rs1, input int rs2, input int rd,
                              input int rw, input int mr, input int pc,
                              input int st, input int fd, input int fe, input int fa, input int fb);
    vec_t r;
    r.v = v[0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0]; r.rd = rd[4:0];
    r.rw = rw[0]; r.mr = mr[0]; r.pc = pc[0];
    r.st = st[0]; r.fd = fd[0]; r.fe = fe[0]; r.fa = fa[1:0]; r.fb = fb[1:0];
    return r;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic pc);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; pcsrc_e = pc;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    //        v rs1 rs2 rd rw mr pc | st fd fe fa fb
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0);  // add x5,x1,x2
    tbl[2]  = mk(1, 5, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0);  // add x6,x5,x1
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0);  // x5 forwarded from MEM
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0);  // add x5,x1,x2
    tbl[6]  = mk(1, 1, 3, 5, 1, 0, 0,  0, 0, 0, 0, 0);  // add x5,x1,x3
    tbl[7]  = mk(1, 5, 5, 7, 1, 0, 0,  0, 0, 0, 0, 0);  // add x7,x5,x5
    tbl[8]  = mk(1, 1, 2, 0, 1, 0, 0,  0, 0, 0, 2, 2);  // add x0,x1,x2 ; EXE sees MEM beat WB
    tbl[9]  = mk(1, 0, 7, 8, 1, 0, 0,  0, 0, 0, 0, 0);  // add x8,x0,x7
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // x0 never forwards, x7 from WB
    tbl[11] = mk(1, 2, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0);  // ld x7
    tbl[12] = mk(1, 7, 3, 9, 1, 0, 0,  1, 0, 1, 0, 0);  // add x9,x7,x3 -> load-use
    tbl[13] = mk(1, 7, 3, 9, 1, 0, 0,  0, 0, 0, 0, 0);  // held, proceeds
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);  // load data from WB
    tbl[15] = mk(1, 2, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0);  // ld x7
    tbl[16] = mk(1, 7, 3, 9, 1, 0, 1,  0, 1, 1, 0, 0);  // load-use + taken branch
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Reset for two cycles, then idle.
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      @(negedge clk);
      chk("rst_a_out", 64'(a_o), 64'(0));
      chk("rst_b_out", 64'(b_o), 64'(0));
      chk("rst_c_out", 64'(c_o), 64'(0));
      chk("rst_cnts", 64'({a_stall_cnt, a_flush_cnt}), 64'(0));
    end
    next_cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_out", 64'({a_o, b_o, c_o}), 64'(0));
      chk("idle_cnt", 64'({b_stall_cnt, c_stall_cnt, c_flush_cnt}), 64'(0));
      next_cyc();
    end

    // Table-driven stream on instance A.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_id(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].pc);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 64'(a_o),
          64'({tbl[i].st, tbl[i].st, tbl[i].fd, tbl[i].fe, tbl[i].fa, tbl[i].fb}));
      next_cyc();
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("a_stall_cnt", 64'(a_stall_cnt), 64'(1));
    chk("a_flush_cnt", 64'(a_flush_cnt), 64'(1));
    next_cyc();

    // LOAD_STALL=2 on instance B: two stall cycles.
    do_reset();
    set_id(1, 2, 0, 7, 1, 1, 0);
    @(negedge clk); chk("ls2_ld", 64'(b_o), 64'(0)); next_cyc();
    set_id(1, 7, 0, 9, 1, 0, 0);
    @(negedge clk); chk("ls2_st1", 64'(b_o), 64'(8'b1101_0000)); next_cyc();
    @(negedge clk); chk("ls2_st2", 64'(b_o), 64'(8'b1101_0000)); next_cyc();
    @(negedge clk); chk("ls2_go", 64'(b_o), 64'(0)); next_cyc();
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("ls2_cnt", 64'(b_stall_cnt), 64'(2));
    chk("ls2_fcnt", 64'(b_flush_cnt), 64'(0)); next_cyc();

    // Reset while B is mid-stall: stall gone on the next cycle.
    set_id(1, 2, 0, 7, 1, 1, 0); next_cyc();
    set_id(1, 7, 0, 9, 1, 0, 0);
    @(negedge clk); chk("rst_mid_st", 64'(b_o), 64'(8'b1101_0000)); next_cyc();
    reset = 1'b1; next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_drop", 64'(b_o), 64'(0));
    chk("rst_mid_cnt", 64'(b_stall_cnt), 64'(0));
    next_cyc();

    // Stall-only instance C.
    do_reset();
    set_id(1, 1, 2, 5, 1, 0, 0);
    @(negedge clk); chk("nf_prod", 64'(c_o), 64'(0)); next_cyc();
    set_id(0, 5, 5, 0, 0, 0, 0);
    @(negedge clk); chk("nf_idvalid0", 64'(c_o), 64'(0)); next_cyc();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cyc();
    for (int p = 0; p < 7; p++) begin
      set_id(1, 1, 2, 5, 1, 0, 0);  // add x5,x1,x2
      next_cyc();
      set_id(1, 5, 1, 6, 1, 0, 0);  // add x6,x5,x1
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("nf_p%0d_k%0d", p, k), 64'(c_o),
            (k < 3) ? 64'(8'b1101_0000) : 64'(0));
        if (p == 0 && k == 3) chk("nf_cnt3", 64'(c_stall_cnt), 64'(3));
        next_cyc();
      end
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("nf_cnt_sat", 64'(c_stall_cnt), 64'(15));
    chk("nf_fcnt", 64'(c_flush_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
